// File: rtl/thread_state_nch_pkg.sv
// Shared definitions for the md5crypt thread-state register file:
// state encodings, error bit positions and the scanner FSM type.
package thread_state_nch_pkg;

  localparam int THREAD_STATE_MSB = 2;
  localparam int THREAD_STATE_W   = THREAD_STATE_MSB + 1;

  localparam logic [THREAD_STATE_MSB:0] THREAD_STATE_NONE   = 3'd0;
  localparam logic [THREAD_STATE_MSB:0] THREAD_STATE_WR_RDY = 3'd1;
  localparam logic [THREAD_STATE_MSB:0] THREAD_STATE_RD_RDY = 3'd2;
  localparam logic [THREAD_STATE_MSB:0] THREAD_STATE_BUSY   = 3'd3;
  localparam logic [THREAD_STATE_MSB:0] THREAD_STATE_DONE   = 3'd4;

  localparam int ERR_W           = 3;
  localparam int ERR_WR_CONFLICT = 0;
  localparam int ERR_SCAN_BUSY   = 1;
  localparam int ERR_WR_RANGE    = 2;

  typedef enum logic {
    SCAN_IDLE = 1'b0,
    SCAN_RUN  = 1'b1
  } scan_fsm_e;

  // Index of the highest set bit; a value of 0 or 1 gives 0.
  function automatic int msb_of(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if (value[i]) r = i;
    end
    return r;
  endfunction

endpackage

// File: rtl/thread_state_nch_scan.sv
// Round-robin scanner: examines one thread state per cycle starting at ptr
// and reports the first thread holding the captured target state.
module thread_scan
  import thread_state_nch_pkg::*;
#(
  parameter int N_THREADS = 12,
  parameter int NUM_W     = 4,
  parameter int STATE_W   = THREAD_STATE_W
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               scan_req,
  input  logic [STATE_W-1:0] scan_state,
  input  logic [STATE_W-1:0] cur_state,
  output logic [NUM_W-1:0]   ptr,
  output logic               scan_busy,
  output logic               scan_valid,
  output logic               scan_miss,
  output logic [NUM_W-1:0]   scan_num,
  output logic               req_ignored
);

  localparam logic [NUM_W-1:0] LAST_THREAD = NUM_W'(N_THREADS - 1);

  scan_fsm_e          fsm_q, fsm_d;
  logic [NUM_W-1:0]   ptr_q, ptr_d;
  logic [NUM_W-1:0]   cnt_q, cnt_d;
  logic [NUM_W-1:0]   num_q, num_d;
  logic [STATE_W-1:0] tgt_q, tgt_d;
  logic               valid_q, valid_d;
  logic               miss_q, miss_d;
  logic [NUM_W-1:0]   ptr_next;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    fsm_d       = fsm_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    num_d       = num_q;
    tgt_d       = tgt_q;
    valid_d     = 1'b0;
    miss_d      = 1'b0;
    req_ignored = 1'b0;
    ptr_next    = (ptr_q == LAST_THREAD) ? '0 : ptr_q + NUM_W'(1);

    case (fsm_q)
      SCAN_IDLE: begin
        if (scan_req) begin
          tgt_d = scan_state;
          cnt_d = '0;
          fsm_d = SCAN_RUN;
        end
      end
      SCAN_RUN: begin
        req_ignored = scan_req;
        // After N_THREADS advances ptr is back at its request-time value,
        // so a miss needs no separate restore register.
        ptr_d = ptr_next;
        if (cur_state == tgt_q) begin
          num_d   = ptr_q;
          valid_d = 1'b1;
          fsm_d   = SCAN_IDLE;
        end else if (cnt_q == LAST_THREAD) begin
          miss_d = 1'b1;
          fsm_d  = SCAN_IDLE;
        end else begin
          cnt_d = cnt_q + NUM_W'(1);
        end
      end
      default: fsm_d = SCAN_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      fsm_q   <= SCAN_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      num_q   <= '0;
      tgt_q   <= '0;
      valid_q <= 1'b0;
      miss_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      num_q   <= num_d;
      tgt_q   <= tgt_d;
      valid_q <= valid_d;
      miss_q  <= miss_d;
    end
  end

  assign ptr        = ptr_q;
  assign scan_busy  = (fsm_q == SCAN_RUN);
  assign scan_valid = valid_q;
  assign scan_miss  = miss_q;
  assign scan_num   = num_q;

endmodule

// File: rtl/thread_state_nch.sv
// Thread-state register file with N_CH independent read/write channels,
// lowest-channel-wins write priority, sticky error flags and a scanner.
module thread_state_nch
  import thread_state_nch_pkg::*;
#(
  parameter int N_THREADS     = 12,
  parameter int N_THREADS_MSB = msb_of(N_THREADS - 1),
  parameter int N_CH          = 4,
  parameter int STATE_W       = THREAD_STATE_MSB + 1
) (
  input  logic                               CLK,
  input  logic                               RST,
  input  logic [N_CH-1:0]                    wr_en,
  input  logic [N_CH*(N_THREADS_MSB+1)-1:0]  wr_num,
  input  logic [N_CH*STATE_W-1:0]            wr_state,
  input  logic [N_CH*(N_THREADS_MSB+1)-1:0]  rd_num,
  output logic [N_CH*STATE_W-1:0]            rd_state,
  input  logic                               scan_req,
  input  logic [STATE_W-1:0]                 scan_state,
  output logic                               scan_busy,
  output logic                               scan_valid,
  output logic                               scan_miss,
  output logic [N_THREADS_MSB:0]             scan_num,
  output logic [ERR_W-1:0]                   err
);

  localparam int               NUM_W       = N_THREADS_MSB + 1;
  localparam logic [NUM_W-1:0] LAST_THREAD = NUM_W'(N_THREADS - 1);
  localparam logic [STATE_W-1:0] STATE_RST = STATE_W'(THREAD_STATE_NONE);

  logic [STATE_W-1:0] state_q [N_THREADS];
  logic [STATE_W-1:0] state_d [N_THREADS];
  logic [STATE_W-1:0] rd_q    [N_CH];
  logic [STATE_W-1:0] rd_d    [N_CH];
  logic [ERR_W-1:0]   err_q, err_d;

  logic [NUM_W-1:0]   wr_num_a   [N_CH];
  logic [STATE_W-1:0] wr_state_a [N_CH];
  logic [NUM_W-1:0]   rd_num_a   [N_CH];

  logic [N_THREADS-1:0] claimed;
  logic                 wr_conflict;
  logic                 wr_range;

  logic [NUM_W-1:0]   scan_ptr;
  logic [STATE_W-1:0] scan_cur;
  logic               req_ignored;

  always_comb begin
    for (int c = 0; c < N_CH; c++) begin
      wr_num_a[c]   = wr_num[c*NUM_W +: NUM_W];
      wr_state_a[c] = wr_state[c*STATE_W +: STATE_W];
      rd_num_a[c]   = rd_num[c*NUM_W +: NUM_W];
    end
  end

  // Channels are visited lowest first; a thread already claimed this cycle
  // rejects later writers, which gives the low channel priority.
  always_comb begin
    state_d     = state_q;
    claimed     = '0;
    wr_conflict = 1'b0;
    wr_range    = 1'b0;
    for (int c = 0; c < N_CH; c++) begin
      if (wr_en[c]) begin
        if (wr_num_a[c] > LAST_THREAD) begin
          wr_range = 1'b1;
        end else if (claimed[wr_num_a[c]]) begin
          wr_conflict = 1'b1;
        end else begin
          state_d[wr_num_a[c]] = wr_state_a[c];
          claimed[wr_num_a[c]] = 1'b1;
        end
      end
    end
  end

  // Reads come from state_q, so a same-cycle write is not yet visible.
  always_comb begin
    for (int c = 0; c < N_CH; c++) begin
      rd_d[c] = (rd_num_a[c] > LAST_THREAD) ? '0 : state_q[rd_num_a[c]];
    end
  end

  always_comb begin
    err_d = err_q;
    err_d[ERR_WR_CONFLICT] = err_q[ERR_WR_CONFLICT] | wr_conflict;
    err_d[ERR_SCAN_BUSY]   = err_q[ERR_SCAN_BUSY]   | req_ignored;
    err_d[ERR_WR_RANGE]    = err_q[ERR_WR_RANGE]    | wr_range;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      // NOTE: the state array is genuine flip-flop storage that must come up
      // as NONE, so it is reset explicitly rather than treated as a RAM.
      for (int t = 0; t < N_THREADS; t++) state_q[t] <= STATE_RST;
      for (int c = 0; c < N_CH; c++) rd_q[c] <= '0;
      err_q <= '0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    rd_state = '0;
    for (int c = 0; c < N_CH; c++) begin
      rd_state[c*STATE_W +: STATE_W] = rd_q[c];
    end
  end

  assign err      = err_q;
  assign scan_cur = state_q[scan_ptr];

  thread_scan #(
    .N_THREADS (N_THREADS),
    .NUM_W     (NUM_W),
    .STATE_W   (STATE_W)
  ) u_scan (
    .CLK         (CLK),
    .RST         (RST),
    .scan_req    (scan_req),
    .scan_state  (scan_state),
    .cur_state   (scan_cur),
    .ptr         (scan_ptr),
    .scan_busy   (scan_busy),
    .scan_valid  (scan_valid),
    .scan_miss   (scan_miss),
    .scan_num    (scan_num),
    .req_ignored (req_ignored)
  );

endmodule

// File: tb/tb_thread_state_nch.sv
// Directed bench for thread_state_nch (12 threads, 4 channels): storage,
// write priority, read-first behaviour, error flags and scanner timing.
module tb_thread_state_nch;
  import thread_state_nch_pkg::*;

  localparam int N_THREADS = 12;
  localparam int N_CH      = 4;
  localparam int NUM_W     = 4;
  localparam int STATE_W   = 3;

  logic                      CLK;
  logic                      RST;
  logic [N_CH-1:0]           wr_en;
  logic [N_CH*NUM_W-1:0]     wr_num;
  logic [N_CH*STATE_W-1:0]   wr_state;
  logic [N_CH*NUM_W-1:0]     rd_num;
  logic [N_CH*STATE_W-1:0]   rd_state;
  logic                      scan_req;
  logic [STATE_W-1:0]        scan_state;
  logic                      scan_busy;
  logic                      scan_valid;
  logic                      scan_miss;
  logic [NUM_W-1:0]          scan_num;
  logic [2:0]                err;

  int n_cmp = 0;
  int n_mis = 0;

  thread_state_nch #(
    .N_THREADS (N_THREADS),
    .N_CH      (N_CH)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .wr_en      (wr_en),
    .wr_num     (wr_num),
    .wr_state   (wr_state),
    .rd_num     (rd_num),
    .rd_state   (rd_state),
    .scan_req   (scan_req),
    .scan_state (scan_state),
    .scan_busy  (scan_busy),
    .scan_valid (scan_valid),
    .scan_miss  (scan_miss),
    .scan_num   (scan_num),
    .err        (err)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_cmp++;
    assert (observed === expected)
    else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic set_wr(input int c, input logic [NUM_W-1:0] num, input logic [STATE_W-1:0] st);
    wr_en[c]                       = 1'b1;
    wr_num[c*NUM_W +: NUM_W]       = num;
    wr_state[c*STATE_W +: STATE_W] = st;
  endtask

  task automatic clear_wr();
    wr_en    = '0;
    wr_num   = '0;
    wr_state = '0;
  endtask

  task automatic set_rd(input int c, input logic [NUM_W-1:0] num);
    rd_num[c*NUM_W +: NUM_W] = num;
  endtask

  function automatic logic [STATE_W-1:0] rd_ch(input int c);
    return rd_state[c*STATE_W +: STATE_W];
  endfunction

  // Issues a scan in the current cycle (cycle 0) and follows it until the
  // result pulse; poke_cyc > 0 raises scan_req again in that cycle.
  task automatic run_scan(input string tag, input logic [STATE_W-1:0] st, input int exp_cyc,
                          input logic exp_hit, input logic [NUM_W-1:0] exp_num, input int poke_cyc);
    int cyc;
    scan_state = st;
    scan_req   = 1'b1;
    tick();
    scan_req = 1'b0;
    cyc      = 1;
    check({tag, "_busy1"}, 32'(scan_busy), 32'(1));
    while (!scan_valid && !scan_miss && cyc < 40) begin
      if (cyc == poke_cyc) begin
        scan_req   = 1'b1;
        scan_state = THREAD_STATE_RD_RDY;
      end
      tick();
      scan_req = 1'b0;
      cyc++;
    end
    check({tag, "_cycle"}, 32'(cyc), 32'(exp_cyc));
    check({tag, "_valid"}, 32'(scan_valid), 32'(exp_hit));
    check({tag, "_miss"}, 32'(scan_miss), 32'(!exp_hit));
    check({tag, "_busy_end"}, 32'(scan_busy), 32'(0));
    if (exp_hit) check({tag, "_num"}, 32'(scan_num), 32'(exp_num));
  endtask

  initial begin
    RST        = 1'b1;
    wr_en      = '0;
    wr_num     = '0;
    wr_state   = '0;
    rd_num     = '0;
    scan_req   = 1'b0;
    scan_state = '0;
    tick();
    tick();
    RST = 1'b0;

    check("rst_rd_state", 32'(rd_state), 32'(0));
    check("rst_err", 32'(err), 32'(0));
    check("rst_busy", 32'(scan_busy), 32'(0));
    check("rst_valid", 32'(scan_valid), 32'(0));
    check("rst_miss", 32'(scan_miss), 32'(0));
    check("rst_scan_num", 32'(scan_num), 32'(0));

    // Every thread (and the out-of-range numbers 12..15) reads 0 on all channels.
    for (int t = 0; t < 16; t++) begin
      for (int c = 0; c < N_CH; c++) set_rd(c, NUM_W'(t));
      tick();
      check($sformatf("rst_read_t%0d", t), 32'(rd_state), 32'(0));
    end
    check("rst_err_after_reads", 32'(err), 32'(0));

    // Write thread 5 on ch1 while ch3 reads it: read-first, then new value.
    set_wr(1, 4'd5, THREAD_STATE_WR_RDY);
    set_rd(3, 4'd5);
    tick();
    clear_wr();
    check("rd_same_cycle", 32'(rd_ch(3)), 32'(THREAD_STATE_NONE));
    tick();
    check("rd_next_cycle", 32'(rd_ch(3)), 32'(THREAD_STATE_WR_RDY));

    // ch0 and ch2 both write thread 7: ch0 (state 3) wins, err[0] set.
    set_wr(0, 4'd7, 3'd3);
    set_wr(2, 4'd7, 3'd1);
    set_rd(0, 4'd7);
    tick();
    clear_wr();
    check("conflict_err", 32'(err), 32'(3'b001));
    check("conflict_rd_old", 32'(rd_ch(0)), 32'(THREAD_STATE_NONE));
    tick();
    check("conflict_winner", 32'(rd_ch(0)), 32'(3'd3));

    // Write to thread 12 is dropped and flags err[2].
    set_wr(1, 4'd12, THREAD_STATE_RD_RDY);
    tick();
    clear_wr();
    check("range_err", 32'(err), 32'(3'b101));

    // Distinct threads in one cycle both land; out-of-range read gives 0.
    set_wr(0, 4'd2, THREAD_STATE_RD_RDY);
    set_wr(3, 4'd9, THREAD_STATE_RD_RDY);
    set_rd(0, 4'd2);
    set_rd(1, 4'd9);
    set_rd(2, 4'd12);
    set_rd(3, 4'd5);
    tick();
    clear_wr();
    tick();
    check("dual_wr_t2", 32'(rd_ch(0)), 32'(THREAD_STATE_RD_RDY));
    check("dual_wr_t9", 32'(rd_ch(1)), 32'(THREAD_STATE_RD_RDY));
    check("rd_out_of_range", 32'(rd_ch(2)), 32'(0));
    check("t5_kept", 32'(rd_ch(3)), 32'(THREAD_STATE_WR_RDY));
    check("dual_wr_no_conflict", 32'(err), 32'(3'b101));

    // Round-robin: ptr 0 finds 2 at examination 3 (result in cycle 4),
    // ptr 3 finds 9 at examination 7, ptr 10 wraps and finds 2 at examination 5.
    run_scan("scan1", THREAD_STATE_RD_RDY, 4, 1'b1, 4'd2, -1);
    run_scan("scan2", THREAD_STATE_RD_RDY, 8, 1'b1, 4'd9, -1);
    run_scan("scan3", THREAD_STATE_RD_RDY, 6, 1'b1, 4'd2, -1);

    // Nobody holds state 6: miss in cycle 13; a mid-scan request sets err[1].
    run_scan("scan_miss", 3'd6, 13, 1'b0, 4'd0, 4);
    check("busy_req_err", 32'(err), 32'(3'b111));

    // ptr must be back at 3, so the next hit is thread 9 at examination 7.
    run_scan("scan_after_miss", THREAD_STATE_RD_RDY, 8, 1'b1, 4'd9, -1);
    tick();
    check("valid_one_cycle", 32'(scan_valid), 32'(0));
    check("idle_busy", 32'(scan_busy), 32'(0));

    // Reset in cycle 4 of a scan (ptr 10, would hit thread 2 in cycle 6).
    scan_state = THREAD_STATE_RD_RDY;
    scan_req   = 1'b1;
    tick();
    scan_req = 1'b0;
    tick();
    tick();
    tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check("abort_valid", 32'(scan_valid), 32'(0));
    check("abort_miss", 32'(scan_miss), 32'(0));
    check("abort_busy", 32'(scan_busy), 32'(0));
    check("abort_err", 32'(err), 32'(0));
    check("abort_scan_num", 32'(scan_num), 32'(0));
    check("abort_rd_state", 32'(rd_state), 32'(0));
    set_rd(0, 4'd2);
    set_rd(1, 4'd9);
    set_rd(2, 4'd7);
    set_rd(3, 4'd5);
    tick();
    check("abort_no_pulse", 32'({scan_valid, scan_miss}), 32'(0));
    check("abort_states_none", 32'(rd_state), 32'(0));

    // With ptr back at 0, thread 0 is found first in the best-case 2 cycles.
    set_wr(0, 4'd11, THREAD_STATE_RD_RDY);
    set_wr(1, 4'd0, THREAD_STATE_RD_RDY);
    tick();
    clear_wr();
    run_scan("scan_best", THREAD_STATE_RD_RDY, 2, 1'b1, 4'd0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
